regfile: RTL and testbench

- 32 x 32-bit general-purpose register file: the responder behind the decode stage's two register read ports, plus one write port driven from write-back.
- Provides two read ports and one write port. Reads are combinational; writes are clocked.
- After reset, a sequencer clears r1..r31 to zero and holds a busy flag the pipeline uses as a stall request.
- r0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_clr_seq.sv | 45 ++++
 rtl/regfile.sv | 97 +++++++++
 tb/tb_regfile.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: bus widths, enable levels, zero constants
// and the clear-sequencer state encodings.
package regfile_pkg;

   localparam int DataW  = 32;
   localparam int AddrW  = 5;
   localparam int RegNum = 32;

   typedef logic [DataW-1:0] RegBus;
   typedef logic [AddrW-1:0] RegAddrBus;

   localparam logic RstEnable   = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;

   localparam RegBus     ZeroWord   = '0;
   localparam RegAddrBus NOPRegAddr = '0;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks r1..r(NREGS-1) once, writing zero, and raises busy
// until the walk completes.
//
// state | meaning
// CLEAR | zeroing mem[clr_idx] each cycle, busy high, normal writes blocked
// READY | steady state, write port and reads open; left only through rst
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = AddrW,
   parameter int NREGS  = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NREGS - 1);

   clr_state_t        state;
   logic [ADDR_W-1:0] clr_idx;

   // clr_idx stops at the last register instead of wrapping back to r0.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state   <= CLEAR;
         clr_idx <= ADDR_W'(1);
      end else if (state == CLEAR) begin
         if (clr_idx == LastIdx) begin
            state <= READY;
         end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
         end
      end
   end

   assign clr_we   = (state == CLEAR) && (rst != RstEnable);
   assign clr_addr = clr_idx;
   assign ready    = (state == READY);
   assign busy     = (rst == RstEnable) || (state == CLEAR);

endmodule

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one clocked write port, r0 fixed at zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W = DataW,
   parameter int ADDR_W = AddrW,
   parameter int NREGS  = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy
);

   localparam logic [DATA_W-1:0] Zero   = DATA_W'(ZeroWord);
   localparam logic [ADDR_W-1:0] NopReg = ADDR_W'(NOPRegAddr);

   logic [DATA_W-1:0] mem [NREGS];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              ready;
   logic              wr_ok;
   logic              byp1;
   logic              byp2;

   regfile_clr_seq #(
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready),
      .busy     (busy)
   );

   // Writes during CLEAR are dropped outright, not queued.
   assign wr_ok = ready && (rst != RstEnable) && (we == WriteEnable) && (waddr != NopReg);

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= Zero;
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign byp1 = wr_ok && (raddr1 == waddr);
   assign byp2 = wr_ok && (raddr2 == waddr);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      rdata1 = Zero;
      if ((rst == RstEnable) || !ready) begin
         rdata1 = Zero;
      end else if (re1 != ReadEnable) begin
         rdata1 = Zero;
      end else if (raddr1 == NopReg) begin
         rdata1 = Zero;
      end else if (byp1) begin
         rdata1 = wdata;
      end else begin
         rdata1 = mem[raddr1];
      end
   end

   always_comb begin
      rdata2 = Zero;
      if ((rst == RstEnable) || !ready) begin
         rdata2 = Zero;
      end else if (re2 != ReadEnable) begin
         rdata2 = Zero;
      end else if (raddr2 == NopReg) begin
         rdata2 = Zero;
      end else if (byp2) begin
         rdata2 = wdata;
      end else begin
         rdata2 = mem[raddr2];
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: clear sequence timing, read/write table, r0, bypass
// (follows REGFILE_BYPASS_EN), writes during clear and reset re-assertion mid-clear.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        re1 = 1'b0;
   logic [4:0]  raddr1 = '0;
   logic [31:0] rdata1;
   logic        re2 = 1'b0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rdata2;
   logic        busy;

   int checks = 0;
   int errors = 0;

   regfile dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after a rising edge; combinational outputs are checked 3ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse rst for one edge, then count busy cycles. Optionally inject a write at clear
   // cycle we_at and a one-cycle rst re-assertion at clear cycle rst_at (count restarts).
   // Read port 1 watches r5 throughout and must stay zero.
   task automatic run_clear(input int we_at, input int rst_at, output int n);
      bit restarted = 1'b0;
      re1    = 1'b1;
      raddr1 = 5'd5;
      rst    = 1'b1;
      #3;
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h1);
      next_cycle();
      rst = 1'b0;
      n   = 0;
      while (busy && n < 100) begin
         n++;
         we    = (n == we_at);
         waddr = 5'd9;
         wdata = 32'h55;
         #3;
         chk("clr_rdata1", rdata1, 32'h0);
         if (n == rst_at && !restarted) begin
            restarted = 1'b1;
            rst = 1'b1;
            next_cycle();
            rst = 1'b0;
            we  = 1'b0;
            #3;
            chk("restart_busy", {31'h0, busy}, 32'h1);
            n = 0;
            continue;
         end
         next_cycle();
      end
      we = 1'b0;
      if (n >= 100) begin
         errors++;
         $display("FAIL clear_timeout: busy still high after %0d cycles", n);
      end
   endtask

   task automatic apply(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
      #3;
   endtask

   int n;

   initial begin
      vecs[0] = '{1'b1, 5'd3,  32'h1234_5678, 1'b1, 5'd4,  1'b0, 5'd3,  32'h0,         32'h0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b1, 5'd3,  32'h1234_5678, 32'h1234_5678};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd3,  32'h0,         32'h1234_5678};
      vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b0, 5'd3,  32'h0,         32'h0};
      vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  1'b1, 5'd3,  32'h0,         32'h1234_5678};
      vecs[5] = '{1'b1, 5'd31, 32'h0000_CAFE, 1'b1, 5'd3,  1'b1, 5'd30, 32'h1234_5678, 32'h0};
      vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 1'b1, 5'd31, 32'h0000_CAFE, 32'h0000_CAFE};
      vecs[7] = '{1'b1, 5'd3,  32'h0000_0001, 1'b1, 5'd31, 1'b1, 5'd31, 32'h0000_CAFE, 32'h0000_CAFE};
      vecs[8] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b1, 5'd31, 32'h0000_0001, 32'h0000_CAFE};

      next_cycle();
      run_clear(0, 0, n);
      chk("clear0_cycles", n, 31);

      // Preload r5 and r31, then reset again: the clear must wipe them.
      apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      next_cycle();
      apply(1'b1, 5'd31, 32'h0BAD_F00D, 1'b1, 5'd5, 1'b0, 5'd0);
      chk("preload_r5", rdata1, 32'hDEAD_BEEF);
      next_cycle();
      we = 1'b0;
      run_clear(0, 0, n);
      chk("clear1_cycles", n, 31);
      apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
      chk("cleared_r5", rdata1, 32'h0);
      chk("cleared_r31", rdata2, 32'h0);
      chk("ready_busy", {31'h0, busy}, 32'h0);
      next_cycle();

      for (int i = 0; i < 9; i++) begin
         apply(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
               vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
         chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
         chk($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
         next_cycle();
      end

      // Same-cycle write and read of r7.
      apply(1'b1, 5'd7, 32'hA5A5_0001, 1'b1, 5'd7, 1'b0, 5'd7);
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same_cycle", rdata1, 32'hA5A5_0001);
`else
      chk("nobypass_same_cycle", rdata1, 32'h0);
`endif
      chk("bypass_re2_off", rdata2, 32'h0);
      next_cycle();
      apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
      chk("r7_after_rdata1", rdata1, 32'hA5A5_0001);
      chk("r7_after_rdata2", rdata2, 32'hA5A5_0001);
      next_cycle();
      // A disabled port never forwards, and r0 is never forwarded.
      apply(1'b1, 5'd8, 32'h0000_0888, 1'b0, 5'd8, 1'b1, 5'd3);
      chk("bypass_re1_off", rdata1, 32'h0);
      chk("r3_during_w8", rdata2, 32'h0000_0001);
      next_cycle();
      apply(1'b1, 5'd0, 32'h7777_7777, 1'b1, 5'd0, 1'b1, 5'd8);
      chk("bypass_r0", rdata1, 32'h0);
      chk("r8_read", rdata2, 32'h0000_0888);
      next_cycle();
      we = 1'b0;

      // Write attempted at clear cycle 10 (r9 already zeroed) must be dropped.
      apply(1'b1, 5'd9, 32'h0000_9999, 1'b0, 5'd0, 1'b0, 5'd0);
      next_cycle();
      we = 1'b0;
      run_clear(10, 0, n);
      chk("clear_we_cycles", n, 31);
      apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd8);
      chk("r9_write_in_clear", rdata1, 32'h0);
      chk("r8_cleared", rdata2, 32'h0);
      next_cycle();

      // Re-assert rst at clear cycle 15; busy must run a full 31 cycles afterwards.
      apply(1'b1, 5'd5, 32'h1357_2468, 1'b0, 5'd0, 1'b0, 5'd0);
      next_cycle();
      we = 1'b0;
      run_clear(0, 15, n);
      chk("restart_cycles", n, 31);
      apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
      chk("restart_r5_p1", rdata1, 32'h0);
      chk("restart_r5_p2", rdata2, 32'h0);
      chk("restart_busy_low", {31'h0, busy}, 32'h0);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
